// File: rtl/flash_read_arbiter.sv
// flash_read_arbiter: shares one SPI flash read engine between two requesters.
// Each grant issues one read command; returned bytes go only to the granted
// requester, which gets a done pulse when the reader reports ready again.
//
// Request handshake: a requester raises valid with addr/count and holds all three
// stable until it sees a 1-cycle ack; valid may drop the cycle after ack. ack,
// dvld and done are single-cycle pulses and are only ever raised to the granted
// requester.
module flash_read_arbiter #(
  parameter int CNT_W      = 14,
  parameter bit FIXED_PRIO = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             req0_valid,
  input  logic [23:0]      req0_addr,
  input  logic [CNT_W-1:0] req0_count,
  output logic             req0_ack,
  output logic [7:0]       req0_data,
  output logic             req0_dvld,
  output logic             req0_done,
  input  logic             req1_valid,
  input  logic [23:0]      req1_addr,
  input  logic [CNT_W-1:0] req1_count,
  output logic             req1_ack,
  output logic [7:0]       req1_data,
  output logic             req1_dvld,
  output logic             req1_done,
  output logic [23:0]      fl_addr,
  output logic [CNT_W-1:0] fl_count,
  output logic             fl_start,
  input  logic             fl_rdy,
  input  logic [7:0]       fl_data,
  input  logic             fl_data_rdy,
  output logic [2:0]       dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_LATCH  = 3'd1,
    S_START  = 3'd2,
    S_WAITLO = 3'd3,
    S_BUSY   = 3'd4,
    S_ZERO   = 3'd5
  } state_t;

  localparam logic [CNT_W:0] BYTE_ONE = {{CNT_W{1'b0}}, 1'b1};

  state_t           state_q, state_d;
  logic             gnt_q, gnt_d;        // granted requester: 0 = req0, 1 = req1
  logic             ptr_q, ptr_d;        // requester preferred on a round-robin tie
  logic [23:0]      fl_addr_q, fl_addr_d;
  logic [CNT_W-1:0] fl_count_q, fl_count_d;
  logic             fl_start_q, fl_start_d;
  logic [1:0]       ack_q, ack_d;
  logic [1:0]       done_q, done_d;
  logic [1:0]       dvld_q, dvld_d;
  logic [7:0]       data0_q, data0_d;
  logic [7:0]       data1_q, data1_d;
  logic [CNT_W:0]   byte_cnt_q, byte_cnt_d;
  logic             pick1;
  logic             byte_room;

  // Next-state, arbitration and registered-output values.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    ptr_d      = ptr_q;
    fl_addr_d  = fl_addr_q;
    fl_count_d = fl_count_q;
    fl_start_d = 1'b0;
    ack_d      = 2'b00;
    done_d     = 2'b00;
    dvld_d     = 2'b00;
    data0_d    = data0_q;
    data1_d    = data1_q;
    byte_cnt_d = byte_cnt_q;
    // A lone valid always wins; on a tie fixed priority favours req0,
    // round-robin favours whoever the pointer names.
    pick1      = req1_valid && (!req0_valid || (!FIXED_PRIO && ptr_q));
    // Bytes beyond the commanded count are dropped rather than forwarded.
    byte_room  = byte_cnt_q < {1'b0, fl_count_q};
    case (state_q)
      S_IDLE: begin
        if (fl_rdy && (req0_valid || req1_valid)) begin
          gnt_d      = pick1;
          fl_addr_d  = pick1 ? req1_addr : req0_addr;
          fl_count_d = pick1 ? req1_count : req0_count;
          byte_cnt_d = '0;
          state_d    = S_LATCH;
        end
      end
      S_LATCH: begin
        ack_d[gnt_q] = 1'b1;
        // A zero-length read would hang the reader, so it never sees one.
        if (fl_count_q == '0) begin
          state_d = S_ZERO;
        end else begin
          fl_start_d = 1'b1;
          state_d    = S_START;
        end
      end
      S_START: begin
        state_d = S_WAITLO;
      end
      S_WAITLO: begin
        if (!fl_rdy) begin
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        if (fl_data_rdy && byte_room) begin
          if (gnt_q) begin
            data1_d = fl_data;
          end else begin
            data0_d = fl_data;
          end
          dvld_d[gnt_q] = 1'b1;
          byte_cnt_d    = byte_cnt_q + BYTE_ONE;
        end
        if (fl_rdy) begin
          done_d[gnt_q] = 1'b1;
          ptr_d         = ~gnt_q;
          state_d       = S_IDLE;
        end
      end
      S_ZERO: begin
        done_d[gnt_q] = 1'b1;
        ptr_d         = ~gnt_q;
        state_d       = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State and output registers; reset abandons any grant without a done.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      gnt_q      <= 1'b0;
      ptr_q      <= 1'b0;
      fl_addr_q  <= '0;
      fl_count_q <= '0;
      fl_start_q <= 1'b0;
      ack_q      <= 2'b00;
      done_q     <= 2'b00;
      dvld_q     <= 2'b00;
      data0_q    <= 8'h00;
      data1_q    <= 8'h00;
      byte_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      ptr_q      <= ptr_d;
      fl_addr_q  <= fl_addr_d;
      fl_count_q <= fl_count_d;
      fl_start_q <= fl_start_d;
      ack_q      <= ack_d;
      done_q     <= done_d;
      dvld_q     <= dvld_d;
      data0_q    <= data0_d;
      data1_q    <= data1_d;
      byte_cnt_q <= byte_cnt_d;
    end
  end

  assign req0_ack  = ack_q[0];
  assign req1_ack  = ack_q[1];
  assign req0_done = done_q[0];
  assign req1_done = done_q[1];
  assign req0_dvld = dvld_q[0];
  assign req1_dvld = dvld_q[1];
  assign req0_data = data0_q;
  assign req1_data = data1_q;
  assign fl_addr   = fl_addr_q;
  assign fl_count  = fl_count_q;
  assign fl_start  = fl_start_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_flash_read_arbiter.sv
// Bench for flash_read_arbiter: a round-robin instance (index 0) and a
// fixed-priority instance (index 1), each with its own flash reader model.
module tb_flash_read_arbiter;
  localparam int CNT_W = 14;

  // clock / reset
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic reset = 1'b1;

  logic             vld   [2][2];
  logic [23:0]      adr   [2][2];
  logic [CNT_W-1:0] cnt   [2][2];
  logic             ack   [2][2];
  logic [7:0]       dat   [2][2];
  logic             dvld  [2][2];
  logic             done  [2][2];
  logic [23:0]      fl_addr  [2];
  logic [CNT_W-1:0] fl_count [2];
  logic             fl_start [2];
  logic             fl_rdy   [2];
  logic [7:0]       fl_data  [2];
  logic             drdy_q   [2];
  logic             inj      [2];
  logic             fl_data_rdy [2];
  logic [2:0]       dbg [2];

  assign fl_data_rdy[0] = drdy_q[0] | inj[0];
  assign fl_data_rdy[1] = drdy_q[1] | inj[1];

  flash_read_arbiter #(.CNT_W(CNT_W), .FIXED_PRIO(1'b0)) dut_rr (
    .clk(clk), .reset(reset),
    .req0_valid(vld[0][0]), .req0_addr(adr[0][0]), .req0_count(cnt[0][0]),
    .req0_ack(ack[0][0]), .req0_data(dat[0][0]), .req0_dvld(dvld[0][0]), .req0_done(done[0][0]),
    .req1_valid(vld[0][1]), .req1_addr(adr[0][1]), .req1_count(cnt[0][1]),
    .req1_ack(ack[0][1]), .req1_data(dat[0][1]), .req1_dvld(dvld[0][1]), .req1_done(done[0][1]),
    .fl_addr(fl_addr[0]), .fl_count(fl_count[0]), .fl_start(fl_start[0]),
    .fl_rdy(fl_rdy[0]), .fl_data(fl_data[0]), .fl_data_rdy(fl_data_rdy[0]),
    .dbg_state(dbg[0])
  );

  flash_read_arbiter #(.CNT_W(CNT_W), .FIXED_PRIO(1'b1)) dut_fp (
    .clk(clk), .reset(reset),
    .req0_valid(vld[1][0]), .req0_addr(adr[1][0]), .req0_count(cnt[1][0]),
    .req0_ack(ack[1][0]), .req0_data(dat[1][0]), .req0_dvld(dvld[1][0]), .req0_done(done[1][0]),
    .req1_valid(vld[1][1]), .req1_addr(adr[1][1]), .req1_count(cnt[1][1]),
    .req1_ack(ack[1][1]), .req1_data(dat[1][1]), .req1_dvld(dvld[1][1]), .req1_done(done[1][1]),
    .fl_addr(fl_addr[1]), .fl_count(fl_count[1]), .fl_start(fl_start[1]),
    .fl_rdy(fl_rdy[1]), .fl_data(fl_data[1]), .fl_data_rdy(fl_data_rdy[1]),
    .dbg_state(dbg[1])
  );

  function automatic logic [7:0] fdata(input logic [23:0] a, input int i);
    return a[7:0] ^ a[15:8] ^ a[23:16] ^ 8'(i * 37 + 1);
  endfunction

  // flash reader model: drops rdy after start, returns count bytes with random gaps
  int          rd_left [2];
  int          rd_idx  [2];
  logic [23:0] rd_addr [2];
  logic        rd_busy [2];
  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      if (reset) begin
        fl_rdy[k]  <= 1'b1;
        rd_busy[k] <= 1'b0;
        drdy_q[k]  <= 1'b0;
        fl_data[k] <= 8'h00;
      end else begin
        drdy_q[k] <= 1'b0;
        if (!rd_busy[k]) begin
          if (fl_start[k]) begin
            rd_busy[k] <= 1'b1;
            fl_rdy[k]  <= 1'b0;
            rd_left[k] <= int'(fl_count[k]);
            rd_addr[k] <= fl_addr[k];
            rd_idx[k]  <= 0;
          end
        end else if (rd_left[k] == 0) begin
          fl_rdy[k]  <= 1'b1;
          rd_busy[k] <= 1'b0;
        end else if ($urandom_range(0, 2) != 0) begin
          drdy_q[k]  <= 1'b1;
          fl_data[k] <= fdata(rd_addr[k], rd_idx[k]);
          rd_idx[k]  <= rd_idx[k] + 1;
          rd_left[k] <= rd_left[k] - 1;
        end
      end
    end
  end

  // scoreboard state
  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;
  int               pend_since [2][2];
  logic [23:0]      pend_addr  [2][2];
  logic [CNT_W-1:0] pend_cnt   [2][2];
  int  n_dvld [2][2];
  int  n_done [2][2];
  int  n_start [2];
  bit  active [2];
  int  owner [2];
  int  last_served [2];
  int  zdone_at [2];
  logic [7:0] exp_q0[$];
  logic [7:0] exp_q1[$];
  int  glog0[$];
  int  glog1[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int qsize(input int k);
    return (k == 0) ? exp_q0.size() : exp_q1.size();
  endfunction

  task automatic qpush(input int k, input logic [7:0] b);
    if (k == 0) exp_q0.push_back(b); else exp_q1.push_back(b);
  endtask

  task automatic qpop(input int k, output logic [7:0] b);
    if (k == 0) b = exp_q0.pop_front(); else b = exp_q1.pop_front();
  endtask

  // Reference: a grant may go only to a request pending when the arbiter sampled it
  // (two cycles before ack); if the other requester was also pending then, fixed
  // priority picks req0 and round-robin picks whoever was not served last.
  task automatic mon(input int k);
    logic [7:0] e;
    bit ok;
    int o;
    if (reset) begin
      active[k] = 1'b0;
      if (k == 0) exp_q0.delete(); else exp_q1.delete();
      last_served[k] = 1;
      zdone_at[k] = -1;
      pend_since[k][0] = -1;
      pend_since[k][1] = -1;
    end else begin
      if (fl_start[k]) begin
        n_start[k]++;
        chk("start_has_ack", ack[k][0] | ack[k][1], 1);
      end
      for (int r = 0; r < 2; r++) begin
        o = 1 - r;
        if (ack[k][r]) begin
          chk("ack_pending", (pend_since[k][r] >= 0 && pend_since[k][r] <= cyc - 2), 1);
          chk("ack_overlap", active[k], 0);
          if (pend_since[k][o] >= 0 && pend_since[k][o] <= cyc - 2)
            chk("arb_winner", r, (k == 1) ? 0 : 1 - last_served[k]);
          chk("start_with_ack", fl_start[k], pend_cnt[k][r] != 0);
          chk("fl_addr", fl_addr[k], pend_addr[k][r]);
          chk("fl_count", fl_count[k], pend_cnt[k][r]);
          active[k] = 1'b1;
          owner[k] = r;
          for (int i = 0; i < int'(pend_cnt[k][r]); i++) qpush(k, fdata(pend_addr[k][r], i));
          zdone_at[k] = (pend_cnt[k][r] == 0) ? cyc + 1 : -1;
          if (k == 0) glog0.push_back(r); else glog1.push_back(r);
          pend_since[k][r] = -1;
        end
        if (dvld[k][r]) begin
          n_dvld[k][r]++;
          ok = active[k] && owner[k] == r && qsize(k) > 0;
          chk("dvld_owner", ok, 1);
          if (ok) begin
            qpop(k, e);
            chk("dvld_data", dat[k][r], e);
          end
        end
        if (done[k][r]) begin
          n_done[k][r]++;
          ok = active[k] && owner[k] == r;
          chk("done_owner", ok, 1);
          if (ok) begin
            chk("done_bytes_left", qsize(k), 0);
            if (zdone_at[k] >= 0) chk("zero_done_cycle", cyc, zdone_at[k]);
            active[k] = 1'b0;
            last_served[k] = r;
          end
        end
      end
    end
    for (int r = 0; r < 2; r++) begin
      if (vld[k][r] && pend_since[k][r] < 0) begin
        pend_since[k][r] = cyc;
        pend_addr[k][r] = adr[k][r];
        pend_cnt[k][r] = cnt[k][r];
      end
    end
  endtask

  always @(negedge clk) begin
    cyc++;
    mon(0);
    mon(1);
  end

  // driver tasks
  task automatic issue(input int k, input int r, input logic [23:0] a,
                       input logic [CNT_W-1:0] c, input int budget);
    int t;
    adr[k][r] = a;
    cnt[k][r] = c;
    vld[k][r] = 1'b1;
    t = 0;
    do begin
      @(posedge clk); #1;
      t++;
    end while (!ack[k][r] && t < budget);
    if (!ack[k][r]) chk("ack_timeout", 0, 1);
    vld[k][r] = 1'b0;
    @(posedge clk); #1;
  endtask

  task automatic wait_idle(input int k);
    int t;
    t = 0;
    while (active[k] && t < 3000) begin
      @(posedge clk); #1;
      t++;
    end
    chk("idle_timeout", active[k], 0);
    repeat (2) @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
  endtask

  task automatic check_zero(input int k, input string tag);
    chk({tag, "_ack0"}, ack[k][0], 0);
    chk({tag, "_ack1"}, ack[k][1], 0);
    chk({tag, "_dvld0"}, dvld[k][0], 0);
    chk({tag, "_dvld1"}, dvld[k][1], 0);
    chk({tag, "_done0"}, done[k][0], 0);
    chk({tag, "_done1"}, done[k][1], 0);
    chk({tag, "_data0"}, dat[k][0], 0);
    chk({tag, "_data1"}, dat[k][1], 0);
    chk({tag, "_fl_addr"}, fl_addr[k], 0);
    chk({tag, "_fl_count"}, fl_count[k], 0);
    chk({tag, "_fl_start"}, fl_start[k], 0);
    chk({tag, "_state"}, dbg[k], 0);
  endtask

  task automatic rand_req(input int k, input int r, input int n, input int maxgap);
    for (int i = 0; i < n; i++) begin
      repeat ($urandom_range(0, maxgap)) @(posedge clk);
      #1;
      issue(k, r, 24'($urandom), CNT_W'($urandom_range(0, 6)), 3000);
    end
  endtask

  typedef struct {
    int               rid;
    logic [23:0]      addr;
    logic [CNT_W-1:0] cnt;
    logic [23:0]      exp_addr;
    logic [CNT_W-1:0] exp_count;
    int               exp_starts;
    int               exp_bytes;
  } vec_t;

  vec_t vt[5];

  initial begin
    int s0, b0, bo, d0;
    int exp_tie[3];
    int exp_fp[4];
    for (int k = 0; k < 2; k++) begin
      inj[k] = 1'b0;
      last_served[k] = 1;
      zdone_at[k] = -1;
      active[k] = 1'b0;
      n_start[k] = 0;
      for (int r = 0; r < 2; r++) begin
        vld[k][r] = 1'b0;
        adr[k][r] = '0;
        cnt[k][r] = '0;
        pend_since[k][r] = -1;
        n_dvld[k][r] = 0;
        n_done[k][r] = 0;
      end
    end
    vt[0] = '{0, 24'h020000, 14'd4, 24'h020000, 14'd4, 1, 4};
    vt[1] = '{1, 24'h123456, 14'd0, 24'h123456, 14'd0, 0, 0};
    vt[2] = '{1, 24'hABCDEF, 14'd1, 24'hABCDEF, 14'd1, 1, 1};
    vt[3] = '{0, 24'hFFFFFF, 14'd3, 24'hFFFFFF, 14'd3, 1, 3};
    vt[4] = '{1, 24'h000100, 14'd9, 24'h000100, 14'd9, 1, 9};

    // reset values
    repeat (3) @(posedge clk);
    @(negedge clk);
    check_zero(0, "reset_rr");
    check_zero(1, "reset_fp");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;

    // directed single requests from the table
    foreach (vt[i]) begin
      s0 = n_start[0];
      b0 = n_dvld[0][vt[i].rid];
      bo = n_dvld[0][1 - vt[i].rid];
      d0 = n_done[0][vt[i].rid];
      issue(0, vt[i].rid, vt[i].addr, vt[i].cnt, 200);
      wait_idle(0);
      chk($sformatf("vec%0d_fl_addr", i), fl_addr[0], vt[i].exp_addr);
      chk($sformatf("vec%0d_fl_count", i), fl_count[0], vt[i].exp_count);
      chk($sformatf("vec%0d_starts", i), n_start[0] - s0, vt[i].exp_starts);
      chk($sformatf("vec%0d_bytes", i), n_dvld[0][vt[i].rid] - b0, vt[i].exp_bytes);
      chk($sformatf("vec%0d_other_bytes", i), n_dvld[0][1 - vt[i].rid] - bo, 0);
      chk($sformatf("vec%0d_done", i), n_done[0][vt[i].rid] - d0, 1);
    end

    // fl_data_rdy while idle must not produce dvld
    b0 = n_dvld[0][0] + n_dvld[0][1];
    inj[0] = 1'b1;
    @(posedge clk); #1;
    inj[0] = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("idle_drdy_ignored", n_dvld[0][0] + n_dvld[0][1] - b0, 0);

    // reset mid-BUSY after 2 of 8 bytes
    b0 = n_dvld[0][0];
    d0 = n_done[0][0];
    issue(0, 0, 24'h040000, 14'd8, 200);
    for (int t = 0; t < 300 && n_dvld[0][0] - b0 < 2; t++) @(negedge clk);
    chk("midbusy_two_bytes", n_dvld[0][0] - b0 >= 2, 1);
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check_zero(0, "midbusy_reset");
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("midbusy_no_done", n_done[0][0] - d0, 0);
    b0 = n_dvld[0][0];
    issue(0, 0, 24'h050000, 14'd5, 200);
    wait_idle(0);
    chk("after_reset_bytes", n_dvld[0][0] - b0, 5);
    chk("after_reset_done", n_done[0][0] - d0, 1);

    // round-robin tie: req0, req1, req0
    do_reset();
    glog0.delete();
    fork
      begin
        issue(0, 0, 24'h001000, 14'd2, 300);
        issue(0, 0, 24'h002000, 14'd2, 300);
      end
      issue(0, 1, 24'h003000, 14'd2, 300);
    join
    wait_idle(0);
    exp_tie = '{0, 1, 0};
    chk("rr_tie_grants", glog0.size(), 3);
    for (int i = 0; i < 3 && i < glog0.size(); i++)
      chk($sformatf("rr_tie_order%0d", i), glog0[i], exp_tie[i]);

    // fixed priority: req0 wins while it keeps requesting
    do_reset();
    glog1.delete();
    fork
      repeat (3) issue(1, 0, 24'($urandom), 14'd2, 300);
      issue(1, 1, 24'h0A0A0A, 14'd2, 300);
    join
    wait_idle(1);
    exp_fp = '{0, 0, 0, 1};
    chk("fp_grants", glog1.size(), 4);
    for (int i = 0; i < 4 && i < glog1.size(); i++)
      chk($sformatf("fp_order%0d", i), glog1[i], exp_fp[i]);

    // randomized traffic on both instances against the scoreboard
    fork
      rand_req(0, 0, 12, 4);
      rand_req(0, 1, 12, 4);
      rand_req(1, 0, 8, 20);
      rand_req(1, 1, 8, 4);
    join
    wait_idle(0);
    wait_idle(1);
    chk("end_queue_rr", qsize(0), 0);
    chk("end_queue_fp", qsize(1), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL global_timeout: bench still running at %0t, limit 900000", $time);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
    $fatal(1, "timeout");
  end

endmodule
